// File: rtl/sel_decoder_pkg.sv
// Shared types for the sequential selector decoder.
//   MODE_W  : width of the request mode field
//   mode_e  : output shape selected per request
//   state_e : control FSM state
package sel_decoder_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ModeOnehot  = 2'd0,
    ModeThermoLo = 2'd1,
    ModeThermoHi = 2'd2,
    ModeScan    = 2'd3
  } mode_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StScan = 1'b1
  } state_e;

endpackage

// File: rtl/sel_decoder_seq_if.sv
// Request/response bundle for sel_decoder_seq.
//   in_valid/in_ready   : request handshake (in_sel, in_mode, in_count)
//   out_valid/out_ready : output word handshake (out_vec, out_err, out_last)
//   busy                : decoder is mid-scan
// slave is the decoder's view, master the requester/consumer view.
interface sel_decoder_seq_if #(
  parameter int unsigned SEL_W   = 5,
  parameter int unsigned NUM_OUT = 32
);
  import sel_decoder_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic [MODE_W-1:0]  in_mode;
  logic [SEL_W-1:0]   in_count;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out_vec;
  logic               out_err;
  logic               out_last;
  logic               busy;

  modport master (
    output in_valid, in_sel, in_mode, in_count, out_ready,
    input  in_ready, out_valid, out_vec, out_err, out_last, busy
  );

  modport slave (
    input  in_valid, in_sel, in_mode, in_count, out_ready,
    output in_ready, out_valid, out_vec, out_err, out_last, busy
  );

endinterface

// File: rtl/sel_decoder_seq_core.sv
// Combinational index decoder.
//   idx_i  : index to decode
//   mode_i : output shape; scan decodes as one-hot
//   vec_o  : decoded vector, all zero when the index is out of range
//   err_o  : idx_i >= NUM_OUT
module sel_decode_core
  import sel_decoder_pkg::*;
#(
  parameter int unsigned SEL_W   = 5,
  parameter int unsigned NUM_OUT = 32
) (
  input  logic [SEL_W-1:0]   idx_i,
  input  mode_e              mode_i,
  output logic [NUM_OUT-1:0] vec_o,
  output logic               err_o
);

  logic [31:0] idx_ext;
  logic        use_lo;
  logic        use_hi;

  assign idx_ext = 32'(idx_i);
  assign err_o   = (idx_ext >= NUM_OUT);
  assign use_lo  = (mode_i == ModeThermoLo);
  assign use_hi  = (mode_i == ModeThermoHi);

  always_comb begin
    vec_o = '0;
    if (!err_o) begin
      for (int unsigned b = 0; b < NUM_OUT; b++) begin
        if (use_lo) begin
          vec_o[b] = (b <= idx_ext);
        end else if (use_hi) begin
          vec_o[b] = (b >= idx_ext);
        end else begin
          vec_o[b] = (b == idx_ext);
        end
      end
    end
  end

endmodule

// File: rtl/sel_decoder_seq.sv
// Registered selector decoder with one-hot / thermometer shapes and a scan
// mode that emits count+1 consecutive one-hot words, wrapping at NUM_OUT.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sel_decoder_seq_if.slave (request in, decoded word out, busy)
// One word per cycle is sustained while the consumer keeps out_ready high.
module sel_decoder_seq
  import sel_decoder_pkg::*;
#(
  parameter int unsigned SEL_W   = 5,
  parameter int unsigned NUM_OUT = 32
) (
  input logic              clk,
  input logic              rst_n,
  sel_decoder_seq_if.slave bus
);

  state_e             state_q;
  logic [SEL_W-1:0]   idx_q;
  logic [SEL_W-1:0]   rem_q;
  logic               out_valid_q;
  logic [NUM_OUT-1:0] out_vec_q;
  logic               out_err_q;
  logic               out_last_q;

  logic [SEL_W-1:0]   next_idx;
  logic [SEL_W-1:0]   core_idx;
  mode_e              core_mode;
  mode_e              req_mode;
  logic [NUM_OUT-1:0] core_vec;
  logic               core_err;
  logic               out_free;
  logic               in_ready;
  logic               accept;

  assign req_mode = mode_e'(bus.in_mode);
  // Output register can take a word if empty or being drained this cycle.
  assign out_free = !out_valid_q || bus.out_ready;
  assign in_ready = (state_q == StIdle) && out_free;
  assign accept   = bus.in_valid && in_ready;
  // Wrap modulo NUM_OUT, not modulo 2**SEL_W.
  assign next_idx = (idx_q == SEL_W'(NUM_OUT - 1)) ? '0 : idx_q + SEL_W'(1);

  // Single decoder shared by request decode (IDLE) and scan stepping (SCAN).
  assign core_idx  = (state_q == StScan) ? next_idx : bus.in_sel;
  assign core_mode = (state_q == StScan) ? ModeOnehot : req_mode;

  sel_decode_core #(
    .SEL_W  (SEL_W),
    .NUM_OUT(NUM_OUT)
  ) u_core (
    .idx_i (core_idx),
    .mode_i(core_mode),
    .vec_o (core_vec),
    .err_o (core_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            out_vec_q   <= core_vec;
            out_err_q   <= core_err;
            out_last_q  <= 1'b1;
            // An out-of-range scan collapses to a single error beat.
            if (req_mode == ModeScan && !core_err) begin
              idx_q <= bus.in_sel;
              rem_q <= bus.in_count;
              if (bus.in_count != '0) begin
                out_last_q <= 1'b0;
                state_q    <= StScan;
              end
            end
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        StScan: begin
          if (out_free) begin
            out_valid_q <= 1'b1;
            out_vec_q   <= core_vec;
            out_err_q   <= core_err;
            idx_q       <= next_idx;
            rem_q       <= rem_q - SEL_W'(1);
            out_last_q  <= (rem_q == SEL_W'(1));
            if (rem_q == SEL_W'(1)) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
